// File: rtl/pooling_layer.sv
// Parallel max/average pooling: pooling_units identical lanes, each reducing K*S unsigned
// pixels to one pixel through a two-stage, start_pool-gated pipeline.
module pooling_layer #(
    parameter int unsigned data_width    = 8,
    parameter int unsigned pooling_units = 4,
    parameter int unsigned K             = 2,
    parameter int unsigned S             = 2
) (
    input  logic                                                 clk,
    input  logic                                                 nrst,
    input  logic                                                 ctrl_pool,
    input  logic                                                 start_pool,
    input  logic [pooling_units-1:0][K*S-1:0][data_width-1:0]    pooling_in,
    output logic [pooling_units-1:0][data_width-1:0]             pooling_out
);

    localparam int unsigned N      = K * S;
    localparam int unsigned NP     = (N + 1) / 2;
    localparam int unsigned PW     = data_width + 1;
    localparam int unsigned LogN   = $clog2(N);
    localparam int unsigned SW     = data_width + LogN;
    localparam bit          IsPow2 = ((N & (N - 1)) == 0);

    // Window zero-padded to an even length; zero is neutral for both unsigned max and sum.
    logic [pooling_units-1:0][2*NP-1:0][data_width-1:0] padded;

    logic [pooling_units-1:0][NP-1:0][data_width-1:0] pmax_d, pmax_q;
    logic [pooling_units-1:0][NP-1:0][PW-1:0]         psum_d, psum_q;
    logic                                             mode_q;
    logic [pooling_units-1:0][data_width-1:0]         result_d, out_q;

    always_comb begin
        padded = '0;
        for (int unsigned l = 0; l < pooling_units; l++) begin
            for (int unsigned i = 0; i < N; i++) begin
                padded[l][i] = pooling_in[l][i];
            end
        end
    end

    // Stage 1: pairwise max and pairwise sum per lane.
    always_comb begin
        pmax_d = '0;
        psum_d = '0;
        for (int unsigned l = 0; l < pooling_units; l++) begin
            for (int unsigned p = 0; p < NP; p++) begin
                pmax_d[l][p] = (padded[l][2*p] > padded[l][2*p+1]) ? padded[l][2*p]
                                                                    : padded[l][2*p+1];
                psum_d[l][p] = PW'(padded[l][2*p]) + PW'(padded[l][2*p+1]);
            end
        end
    end

    // Stage 2: finish the reduction using the mode that travelled with this window.
    always_comb begin
        logic [data_width-1:0] m;
        logic [SW-1:0]         s;
        logic [SW-1:0]         avg;
        result_d = '0;
        m        = '0;
        s        = '0;
        avg      = '0;
        for (int unsigned l = 0; l < pooling_units; l++) begin
            m = pmax_q[l][0];
            s = '0;
            for (int unsigned p = 0; p < NP; p++) begin
                if (pmax_q[l][p] > m) begin
                    m = pmax_q[l][p];
                end
                s = s + SW'(psum_q[l][p]);
            end
            avg         = IsPow2 ? (s >> LogN) : (s / SW'(N));
            result_d[l] = mode_q ? m : data_width'(avg);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pmax_q <= '0;
            psum_q <= '0;
            mode_q <= 1'b0;
            out_q  <= '0;
        end else if (start_pool) begin
            pmax_q <= pmax_d;
            psum_q <= psum_d;
            mode_q <= ctrl_pool;
            out_q  <= result_d;
        end
    end

    assign pooling_out = out_q;

endmodule

// File: tb/tb_pooling_layer.sv
// Directed self-checking bench for pooling_layer with N=4, data_width=8, four lanes.
module tb_pooling_layer;

    localparam int unsigned DW = 8;
    localparam int unsigned PU = 4;
    localparam int unsigned N  = 4;

    logic                         clk = 1'b0;
    logic                         nrst;
    logic                         ctrl_pool;
    logic                         start_pool;
    logic [PU-1:0][N-1:0][DW-1:0] pooling_in;
    logic [PU-1:0][DW-1:0]        pooling_out;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [7:0] w_tab   [0:5][0:3];
    logic       m_tab   [0:5];
    logic [7:0] exp_tab [0:5];

    always #5 clk = ~clk;

    pooling_layer #(
        .data_width    (DW),
        .pooling_units (PU),
        .K             (2),
        .S             (2)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .ctrl_pool   (ctrl_pool),
        .start_pool  (start_pool),
        .pooling_in  (pooling_in),
        .pooling_out (pooling_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int l, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
        pooling_in[l][0] = e0;
        pooling_in[l][1] = e1;
        pooling_in[l][2] = e2;
        pooling_in[l][3] = e3;
    endtask

    task automatic set_all(input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
        for (int l = 0; l < int'(PU); l++) set_lane(l, e0, e1, e2, e3);
    endtask

    task automatic set_main();
        set_lane(3, 8'd1, 8'd5, 8'd6, 8'd7);
        set_lane(2, 8'd2, 8'd1, 8'd8, 8'd9);
        set_lane(1, 8'd3, 8'd1, 8'd2, 8'd4);
        set_lane(0, 8'd4, 8'd5, 8'd0, 8'd1);
    endtask

    task automatic check_lanes(input string tag, input logic [7:0] x3, input logic [7:0] x2,
                               input logic [7:0] x1, input logic [7:0] x0);
        check({tag, "_l3"}, 32'(pooling_out[3]), 32'(x3));
        check({tag, "_l2"}, 32'(pooling_out[2]), 32'(x2));
        check({tag, "_l1"}, 32'(pooling_out[1]), 32'(x1));
        check({tag, "_l0"}, 32'(pooling_out[0]), 32'(x0));
    endtask

    initial begin
        // Same window twice with opposite modes exposes any mode/data misalignment.
        w_tab[0] = '{8'd10, 8'd20, 8'd30, 8'd41};  m_tab[0] = 1'b1; exp_tab[0] = 8'd41;
        w_tab[1] = '{8'd10, 8'd20, 8'd30, 8'd41};  m_tab[1] = 1'b0; exp_tab[1] = 8'd25;
        w_tab[2] = '{8'd100, 8'd3, 8'd7, 8'd250};  m_tab[2] = 1'b1; exp_tab[2] = 8'd250;
        w_tab[3] = '{8'd100, 8'd3, 8'd7, 8'd250};  m_tab[3] = 1'b0; exp_tab[3] = 8'd90;
        w_tab[4] = '{8'd0, 8'd0, 8'd0, 8'd3};      m_tab[4] = 1'b1; exp_tab[4] = 8'd3;
        w_tab[5] = '{8'd0, 8'd0, 8'd0, 8'd3};      m_tab[5] = 1'b0; exp_tab[5] = 8'd0;

        nrst       = 1'b0;
        start_pool = 1'b1;
        ctrl_pool  = 1'b1;
        for (int l = 0; l < int'(PU); l++) begin
            set_lane(l, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        #2;
        check_lanes("reset_async", 8'd0, 8'd0, 8'd0, 8'd0);
        for (int c = 0; c < 3; c++) begin
            for (int l = 0; l < int'(PU); l++) begin
                set_lane(l, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            end
            step();
        end
        check_lanes("reset_held", 8'd0, 8'd0, 8'd0, 8'd0);

        start_pool = 1'b0;
        nrst       = 1'b1;
        step();
        step();
        step();
        check_lanes("idle_after_reset", 8'd0, 8'd0, 8'd0, 8'd0);

        // Max mode: two enabled edges of latency, stable on the third.
        set_main();
        ctrl_pool  = 1'b1;
        start_pool = 1'b1;
        step();
        step();
        check_lanes("max", 8'd7, 8'd9, 8'd4, 8'd5);
        step();
        check_lanes("max_hold", 8'd7, 8'd9, 8'd4, 8'd5);

        // Average mode, lane3 sum 19 truncates to 4.
        ctrl_pool = 1'b0;
        step();
        step();
        check_lanes("avg", 8'd4, 8'd5, 8'd2, 8'd2);

        set_all(8'd255, 8'd255, 8'd255, 8'd255);
        ctrl_pool = 1'b1;
        step();
        step();
        check_lanes("sat_max", 8'd255, 8'd255, 8'd255, 8'd255);
        ctrl_pool = 1'b0;
        step();
        step();
        check_lanes("sat_avg", 8'd255, 8'd255, 8'd255, 8'd255);
        set_all(8'd255, 8'd254, 8'd255, 8'd255);
        step();
        step();
        check_lanes("avg_1019", 8'd254, 8'd254, 8'd254, 8'd254);

        // Stall: main window enters stage 1, then the pipeline freezes for 5 cycles.
        set_main();
        ctrl_pool = 1'b1;
        step();
        start_pool = 1'b0;
        for (int c = 0; c < 5; c++) begin
            set_all(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            ctrl_pool = 1'($urandom);
            step();
            check($sformatf("stall_c%0d", c), 32'(pooling_out[0]), 32'd254);
        end
        check_lanes("stall_end", 8'd254, 8'd254, 8'd254, 8'd254);
        start_pool = 1'b1;
        step();
        check_lanes("stall_resume", 8'd7, 8'd9, 8'd4, 8'd5);

        // Mode alignment; each lane sees the window rotated, which must not matter.
        for (int i = 0; i < 6; i++) begin
            for (int l = 0; l < int'(PU); l++) begin
                set_lane(l, w_tab[i][l % 4], w_tab[i][(l + 1) % 4],
                         w_tab[i][(l + 2) % 4], w_tab[i][(l + 3) % 4]);
            end
            ctrl_pool = m_tab[i];
            step();
            if (i > 0) begin
                for (int l = 0; l < int'(PU); l++) begin
                    check($sformatf("align_w%0d_l%0d", i - 1, l), 32'(pooling_out[l]),
                          32'(exp_tab[i-1]));
                end
            end
        end
        step();
        for (int l = 0; l < int'(PU); l++) begin
            check($sformatf("align_w5_l%0d", l), 32'(pooling_out[l]), 32'(exp_tab[5]));
        end

        // Reset mid-stream discards in-flight data; first valid output after 2 enabled edges.
        set_main();
        ctrl_pool = 1'b1;
        step();
        #2;
        nrst = 1'b0;
        #1;
        check_lanes("midreset_async", 8'd0, 8'd0, 8'd0, 8'd0);
        step();
        nrst = 1'b1;
        step();
        check_lanes("midreset_edge1", 8'd0, 8'd0, 8'd0, 8'd0);
        step();
        check_lanes("midreset_edge2", 8'd7, 8'd9, 8'd4, 8'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
